// File: rtl/cpu_pkg.sv
// Shared CPU package: register-file geometry and common types.
// Imported by the write-back stage, its decoder and its bus interface.
package cpu_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t XZR = 5'd31;

endpackage

// File: rtl/regfile_writeback_if.sv
// Write-back / register-read bus between the pipeline and the register file.
// master drives WB and read addresses; slave is the register file.
interface regfile_writeback_if;
    import cpu_pkg::*;

    logic            wb_valid;
    reg_idx_t        wb_addr;
    word_t           wb_data;
    logic            wb_stall;
    reg_idx_t        rd_addr_a;
    reg_idx_t        rd_addr_b;
    word_t           rd_data_a;
    word_t           rd_data_b;
    logic [NREG-1:0] wr_en_1h;

    modport master (
        output wb_valid, wb_addr, wb_data, wb_stall,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_en_1h
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wb_stall,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_en_1h
    );

endinterface

// File: rtl/regfile_writeback_decode_5to32.sv
// 5:32 one-hot decoder: a 2:4 predecode on the upper bits gates
// four 3:8 decoders on the lower bits.
module decode_5to32
    import cpu_pkg::*;
(
    input  logic      en_i,
    input  reg_idx_t  addr_i,
    output logic [31:0] onehot_o
);

    logic [3:0] grp;

    // 2:4 predecode of addr[4:3], qualified by the enable
    always_comb begin
        grp = '0;
        grp[addr_i[4:3]] = en_i;
    end

    // four 3:8 decoders on addr[2:0], each gated by its group line
    always_comb begin
        onehot_o = '0;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 8; i++) begin
                onehot_o[g*8+i] = grp[g] & (addr_i[2:0] == 3'(i));
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage and architectural register file: one write port,
// two combinational read ports with WB forwarding, X31 reads as zero.
module regfile_writeback
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    regfile_writeback_if.slave bus
);

    localparam logic [NREG-1:0] XZR_MASK = NREG'(1) << XZR;

    logic            we;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] wr_en;
    word_t           regs_q [NREG];
    logic            fwd_a;
    logic            fwd_b;
    word_t           mux_a;
    word_t           mux_b;

    // reset and stall both kill the write, and with it forwarding
    assign we = bus.wb_valid & ~bus.wb_stall & reset_n;

    decode_5to32 u_dec (
        .en_i     (we),
        .addr_i   (bus.wb_addr),
        .onehot_o (dec)
    );

    // X31 never gets a write enable
    assign wr_en        = dec & ~XZR_MASK;
    assign bus.wr_en_1h = wr_en;

    // storage: synchronous clear, per-register enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (wr_en[k]) begin
                    regs_q[k] <= bus.wb_data;
                end
            end
        end
    end

    // forwarding compare runs in parallel with the 32:1 muxes
    always_comb begin
        fwd_a = we && (bus.wb_addr == bus.rd_addr_a);
        fwd_b = we && (bus.wb_addr == bus.rd_addr_b);
        mux_a = regs_q[bus.rd_addr_a];
        mux_b = regs_q[bus.rd_addr_b];
    end

    // read port A: zero for XZR or during reset, else forward or stored
    always_comb begin
        bus.rd_data_a = mux_a;
        if (fwd_a) begin
            bus.rd_data_a = bus.wb_data;
        end
        if (!reset_n || bus.rd_addr_a == XZR) begin
            bus.rd_data_a = '0;
        end
    end

    // read port B: same selection as port A
    always_comb begin
        bus.rd_data_b = mux_b;
        if (fwd_b) begin
            bus.rd_data_b = bus.wb_data;
        end
        if (!reset_n || bus.rd_addr_b == XZR) begin
            bus.rd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Inputs change after negedge; outputs are checked before the next posedge.
module tb_regfile_writeback;
    import cpu_pkg::*;

    logic clk;
    logic reset_n;
    int   n_total;
    int   n_pass;

    regfile_writeback_if bus ();

    regfile_writeback dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_wb();
        bus.wb_valid = 1'b0;
        bus.wb_stall = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
    endtask

    initial begin
        word_t exp_v;
        n_total = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        idle_wb();
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd1;

        // reset held for two cycles
        tick();
        tick();
        #1;
        check("rst_wren", 64'(bus.wr_en_1h), 64'h0);
        check("rst_rda", bus.rd_data_a, 64'h0);
        check("rst_rdb", bus.rd_data_b, 64'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(30 - i);
            #1;
            check($sformatf("post_rst_a%0d", i), bus.rd_data_a, 64'h0);
            check($sformatf("post_rst_b%0d", i), bus.rd_data_b, 64'h0);
        end

        // basic write to X5
        @(negedge clk);
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd5;
        bus.wb_data   = 64'hDEAD_BEEF_0000_0001;
        bus.rd_addr_a = 5'd0;
        #1;
        check("wr5_wren", 64'(bus.wr_en_1h), 64'h0000_0020);
        tick();
        idle_wb();
        bus.rd_addr_a = 5'd5;
        #1;
        check("wr5_rd", bus.rd_data_a, 64'hDEAD_BEEF_0000_0001);
        check("wr5_wren_off", 64'(bus.wr_en_1h), 64'h0);

        // write to X31 is discarded
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd31;
        bus.wb_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.rd_addr_b = 5'd31;
        #1;
        check("x31_wren", 64'(bus.wr_en_1h), 64'h0);
        check("x31_same", bus.rd_data_b, 64'h0);
        tick();
        idle_wb();
        #1;
        check("x31_after", bus.rd_data_b, 64'h0);

        // same-cycle forwarding on both ports
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd7;
        bus.wb_data   = 64'h1234;
        bus.rd_addr_a = 5'd7;
        bus.rd_addr_b = 5'd7;
        #1;
        check("fwd_a", bus.rd_data_a, 64'h1234);
        check("fwd_b", bus.rd_data_b, 64'h1234);
        check("fwd_wren", 64'(bus.wr_en_1h), 64'h0000_0080);
        tick();
        idle_wb();
        #1;
        check("fwd_stored", bus.rd_data_a, 64'h1234);

        // stall suppresses write and forwarding
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        bus.wb_data  = 64'hAA;
        tick();
        bus.wb_stall  = 1'b1;
        bus.wb_data   = 64'hBB;
        bus.rd_addr_a = 5'd3;
        #1;
        check("stall_rd", bus.rd_data_a, 64'hAA);
        check("stall_wren", 64'(bus.wr_en_1h), 64'h0);
        tick();
        idle_wb();
        #1;
        check("stall_hold", bus.rd_data_a, 64'hAA);

        // reset beats a simultaneous write
        bus.wb_valid  = 1'b1;
        bus.wb_addr   = 5'd9;
        bus.wb_data   = 64'h55;
        bus.rd_addr_a = 5'd9;
        bus.rd_addr_b = 5'd5;
        reset_n       = 1'b0;
        #1;
        check("rstw_wren", 64'(bus.wr_en_1h), 64'h0);
        check("rstw_rd", bus.rd_data_a, 64'h0);
        tick();
        reset_n = 1'b1;
        idle_wb();
        #1;
        check("rstw_x9", bus.rd_data_a, 64'h0);
        check("rstw_x5", bus.rd_data_b, 64'h0);

        // sweep all writable registers with unique data
        for (int i = 0; i < 31; i++) begin
            bus.wb_valid = 1'b1;
            bus.wb_addr  = 5'(i);
            bus.wb_data  = 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(i);
            #1;
            check($sformatf("sweep_wren%0d", i), 64'(bus.wr_en_1h),
                  64'h1 << i);
            tick();
        end
        idle_wb();
        for (int i = 0; i < 31; i++) begin
            bus.rd_addr_a = 5'(i);
            bus.rd_addr_b = 5'(30 - i);
            #1;
            exp_v = 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(i);
            check($sformatf("sweep_a%0d", i), bus.rd_data_a, exp_v);
            exp_v = 64'hA5A5_0000_0000_0000 | (64'(30 - i) << 8)
                    | 64'(30 - i);
            check($sformatf("sweep_b%0d", i), bus.rd_data_b, exp_v);
        end
        bus.rd_addr_a = 5'd31;
        #1;
        check("sweep_x31", bus.rd_data_a, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
